// File: rtl/csr_counter_bank_if.sv
// CSR port between the core's CSR unit and the machine counter bank.
interface csr_counter_bank_if #(parameter int CSR_XLEN = 32);
  logic                instret_i;
  logic                csr_re_i;
  logic                csr_we_i;
  logic [11:0]         csr_addr_i;
  logic [CSR_XLEN-1:0] csr_wdata_i;
  logic [CSR_XLEN-1:0] csr_rdata_o;
  logic                csr_rvalid_o;
  logic                csr_illegal_o;

  modport master (
    output instret_i, csr_re_i, csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_rvalid_o, csr_illegal_o
  );
  modport slave (
    input  instret_i, csr_re_i, csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_rvalid_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_counter_bank.sv
// 64-bit mcycle/minstret bank with a 32-bit CSR read/write port.
// Optional mcountinhibit at 0x320 when CSR_COUNTER_INHIBIT_EN is defined.
module csr_counter_bank #(
  parameter logic [63:0] CYCLE_RST   = 64'h0,
  parameter logic [63:0] INSTRET_RST = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  csr_counter_bank_if.slave bus
);
  localparam logic [11:0] A_MCYC_L = 12'hB00, A_MCYC_H = 12'hB80;
  localparam logic [11:0] A_MINS_L = 12'hB02, A_MINS_H = 12'hB82;
  localparam logic [11:0] A_UCYC_L = 12'hC00, A_UCYC_H = 12'hC80;
  localparam logic [11:0] A_UINS_L = 12'hC02, A_UINS_H = 12'hC82;
  localparam logic [11:0] A_INHIBIT = 12'h320;

  logic [63:0] mcycle, minstret;
  logic [63:0] cyc_sum, ins_sum, cyc_nxt, ins_nxt;
  logic        inh_cy, inh_ir;
  logic        sel_cyc_l, sel_cyc_h, sel_ins_l, sel_ins_h, sel_inh;
  logic        illegal, wr, rd;
  logic [31:0] rd_val;

  always_comb begin
    sel_cyc_l = (bus.csr_addr_i == A_MCYC_L) || (bus.csr_addr_i == A_UCYC_L);
    sel_cyc_h = (bus.csr_addr_i == A_MCYC_H) || (bus.csr_addr_i == A_UCYC_H);
    sel_ins_l = (bus.csr_addr_i == A_MINS_L) || (bus.csr_addr_i == A_UINS_L);
    sel_ins_h = (bus.csr_addr_i == A_MINS_H) || (bus.csr_addr_i == A_UINS_H);
`ifdef CSR_COUNTER_INHIBIT_EN
    sel_inh   = (bus.csr_addr_i == A_INHIBIT);
`else
    sel_inh   = 1'b0;
`endif
    // An illegal access drops both its read and its write.
    illegal = (bus.csr_re_i || bus.csr_we_i) &&
              (!(sel_cyc_l || sel_cyc_h || sel_ins_l || sel_ins_h || sel_inh) ||
               (bus.csr_we_i && bus.csr_addr_i[11:8] == 4'hC));
    wr = bus.csr_we_i && !illegal;
    rd = bus.csr_re_i && !illegal;
  end

  always_comb begin
    rd_val = '0;
    if (sel_cyc_l)      rd_val = mcycle[31:0];
    else if (sel_cyc_h) rd_val = mcycle[63:32];
    else if (sel_ins_l) rd_val = minstret[31:0];
    else if (sel_ins_h) rd_val = minstret[63:32];
    else if (sel_inh)   rd_val = {29'b0, inh_ir, 1'b0, inh_cy};
  end

  // Writes win over increments: a low write suppresses the carry, a high write
  // keeps the low-half increment but drops its carry out.
  always_comb begin
    cyc_sum = mcycle + {63'b0, ~inh_cy};
    ins_sum = minstret + {63'b0, bus.instret_i & ~inh_ir};
    cyc_nxt = cyc_sum;
    ins_nxt = ins_sum;
    if (wr && sel_cyc_l)      cyc_nxt = {mcycle[63:32], bus.csr_wdata_i};
    else if (wr && sel_cyc_h) cyc_nxt = {bus.csr_wdata_i, cyc_sum[31:0]};
    if (wr && sel_ins_l)      ins_nxt = {minstret[63:32], bus.csr_wdata_i};
    else if (wr && sel_ins_h) ins_nxt = {bus.csr_wdata_i, ins_sum[31:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle            <= CYCLE_RST;
      minstret          <= INSTRET_RST;
      bus.csr_rdata_o   <= '0;
      bus.csr_rvalid_o  <= 1'b0;
      bus.csr_illegal_o <= 1'b0;
    end else begin
      mcycle            <= cyc_nxt;
      minstret          <= ins_nxt;
      bus.csr_rvalid_o  <= rd;
      bus.csr_illegal_o <= illegal;
      if (rd) bus.csr_rdata_o <= rd_val;
    end
  end

`ifdef CSR_COUNTER_INHIBIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_cy <= 1'b0;
      inh_ir <= 1'b0;
    end else if (wr && sel_inh) begin
      inh_cy <= bus.csr_wdata_i[0];
      inh_ir <= bus.csr_wdata_i[2];
    end
  end
`else
  assign inh_cy = 1'b0;
  assign inh_ir = 1'b0;
`endif
endmodule

// File: tb/tb_csr_counter_bank.sv
// Scoreboard bench for csr_counter_bank: directed plan items, an async-reset abort, then random traffic.
module tb_csr_counter_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_counter_bank_if bus ();
  csr_counter_bank dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int stamp; bit ill; logic [31:0] data; } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_err = 0, cyc_cnt = 0;
  bit running = 1'b0;
  logic [31:0] exp_hold = '0;
  logic [63:0] m_cyc, m_ins;
  bit m_inh_cy, m_inh_ir;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic bit legal(input bit we, input logic [11:0] a);
    bit in_map;
    in_map = (a == 12'hB00) || (a == 12'hB80) || (a == 12'hB02) || (a == 12'hB82) ||
             (a == 12'hC00) || (a == 12'hC80) || (a == 12'hC02) || (a == 12'hC82);
`ifdef CSR_COUNTER_INHIBIT_EN
    if (a == 12'h320) in_map = 1'b1;
`endif
    if (we && a[11:8] == 4'hC) return 1'b0;
    return in_map;
  endfunction

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    case (a)
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'h320:          return (m_inh_cy ? 32'd1 : 32'd0) + (m_inh_ir ? 32'd4 : 32'd0);
      default:          return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_cyc = 64'h0; m_ins = 64'h0; m_inh_cy = 1'b0; m_inh_ir = 1'b0;
  endtask

  // Drive one cycle, push its expected response, advance the reference model.
  task automatic cycle(input bit re, input bit we, input logic [11:0] a,
                       input logic [31:0] w, input bit ir);
    exp_t e;
    bit ok;
    logic [63:0] nc, ni;
    logic [31:0] lo;
    bus.csr_re_i = re; bus.csr_we_i = we; bus.csr_addr_i = a;
    bus.csr_wdata_i = w; bus.instret_i = ir;
    ok = legal(we, a);
    e.stamp = cyc_cnt + 1;
    if (re || we) begin
      if (!ok) begin e.ill = 1'b1; e.data = '0; q.push_back(e); end
      else if (re) begin e.ill = 1'b0; e.data = model_rd(a); q.push_back(e); end
    end
    nc = m_inh_cy ? m_cyc : m_cyc + 64'd1;
    ni = (ir && !m_inh_ir) ? m_ins + 64'd1 : m_ins;
    if (ok && we) begin
      case (a)
        12'hB00: nc = {m_cyc[63:32], w};
        12'hB80: begin lo = nc[31:0]; nc = {w, lo}; end
        12'hB02: ni = {m_ins[63:32], w};
        12'hB82: begin lo = ni[31:0]; ni = {w, lo}; end
        12'h320: begin m_inh_cy = w[0]; m_inh_ir = w[2]; end
        default: ;
      endcase
    end
    m_cyc = nc; m_ins = ni;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit ir);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 12'h000, 32'h0, ir);
  endtask

  // Monitor: pops on every DUT pulse, flags late/missing ones, tracks the held read data.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && running) begin
      if (bus.csr_rvalid_o && bus.csr_illegal_o) chk("pulse_exclusive", 1, 0);
      if (bus.csr_rvalid_o || bus.csr_illegal_o) begin
        if (q.size() == 0) chk("unexpected_pulse", {bus.csr_rvalid_o, bus.csr_illegal_o}, 0);
        else begin
          e = q.pop_front();
          chk("pulse_cycle", cyc_cnt, e.stamp);
          chk("pulse_kind_illegal", bus.csr_illegal_o, e.ill);
          if (!e.ill) exp_hold = e.data;
        end
      end else if (q.size() > 0 && q[0].stamp <= cyc_cnt) begin
        e = q.pop_front();
        chk("missing_pulse", 0, e.stamp);
      end
      chk("rdata", bus.csr_rdata_o, exp_hold);
    end
  end

  logic [11:0] addrs [10];

  initial begin
    bus.csr_re_i = 0; bus.csr_we_i = 0; bus.csr_addr_i = '0;
    bus.csr_wdata_i = '0; bus.instret_i = 0;
    addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
              12'hC80, 12'hC02, 12'hC82, 12'h320, 12'h7FF};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bus.csr_rdata_o, 0);
    chk("rst_rvalid", bus.csr_rvalid_o, 0);
    chk("rst_illegal", bus.csr_illegal_o, 0);
    rst_n = 1'b1;
    running = 1'b1;

    // Idle count, carry into high half, high write drops carry.
    idle(10, 1'b0);
    cycle(1, 0, 12'hB00, 0, 0);
    cycle(1, 0, 12'hB80, 0, 0);
    cycle(0, 1, 12'hB00, 32'hFFFF_FFFF, 0);
    idle(1, 0);
    cycle(1, 0, 12'hB80, 0, 0);
    cycle(0, 1, 12'hB00, 32'hFFFF_FFFF, 0);
    cycle(0, 1, 12'hB80, 32'h5, 0);
    cycle(1, 0, 12'hB00, 0, 0);
    cycle(1, 0, 12'hC80, 0, 0);
    // Read-modify-write of minstret low half while retiring.
    cycle(0, 1, 12'hB82, 32'h0, 0);
    cycle(0, 1, 12'hB02, 32'h7, 0);
    cycle(1, 1, 12'hB02, 32'hABCD_0123, 1);
    cycle(1, 0, 12'hB02, 0, 0);
    cycle(1, 0, 12'hC82, 0, 1);
    // Illegal accesses.
    cycle(0, 1, 12'hC00, 32'h1234, 1);
    cycle(1, 0, 12'h7FF, 0, 0);
    cycle(1, 1, 12'hC02, 32'h55, 1);
    cycle(1, 0, 12'h320, 0, 0);
    cycle(1, 0, 12'hB00, 0, 0);
    cycle(1, 0, 12'hB02, 0, 0);
`ifdef CSR_COUNTER_INHIBIT_EN
    cycle(0, 1, 12'h320, 32'hFFFF_FFFF, 0);
    cycle(1, 0, 12'h320, 0, 0);
    cycle(0, 1, 12'h320, 32'h5, 1);
    idle(20, 1);
    cycle(1, 0, 12'hB00, 0, 1);
    cycle(1, 0, 12'hB02, 0, 1);
    cycle(1, 0, 12'h320, 0, 1);
    cycle(0, 1, 12'hB00, 32'h100, 1);
    cycle(1, 0, 12'hB00, 0, 1);
    cycle(0, 1, 12'h320, 32'h0, 1);
    idle(3, 1);
    cycle(1, 0, 12'hB00, 0, 1);
`endif

    // Async reset in the middle of a read aborts it.
    idle(1, 0);
    bus.csr_re_i = 1; bus.csr_addr_i = 12'hB00;
    #2 rst_n = 1'b0;
    bus.csr_re_i = 0;
    q.delete();
    exp_hold = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("abort_rdata", bus.csr_rdata_o, 0);
    chk("abort_rvalid", bus.csr_rvalid_o, 0);
    chk("abort_illegal", bus.csr_illegal_o, 0);
    rst_n = 1'b1;
    idle(2, 0);
    cycle(1, 0, 12'hB00, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      logic [31:0] w;
      a = ($urandom_range(0, 15) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 9)];
      w = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, w,
            1'($urandom_range(0, 1)));
    end
    cycle(1, 0, 12'hB80, 0, 0);
    cycle(1, 0, 12'hB82, 0, 0);
    idle(3, 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
